// File: rtl/pll_dyn_pkg.sv
// Shared types and constants for the dynamic PLL loop-filter controller.
package pll_dyn_pkg;

  localparam int ICP_W = 6;
  localparam int RES_W = 3;
  localparam int CAP_W = 2;

  localparam logic [ICP_W-1:0] DEF_ICP_C = 6'd20;
  localparam logic [RES_W-1:0] DEF_RES_C = 3'd2;
  localparam logic [CAP_W-1:0] DEF_CAP_C = 2'd0;

  typedef enum logic [1:0] {
    S_RST    = 2'd0,
    S_WAIT   = 2'd1,
    S_LOCKED = 2'd2,
    S_FAIL   = 2'd3
  } state_e;

  typedef struct packed {
    logic [ICP_W-1:0] icp;
    logic [RES_W-1:0] res;
    logic [CAP_W-1:0] cap;
  } filt_t;

  function automatic logic holds_pll_reset(input state_e s);
    return (s == S_RST) || (s == S_FAIL);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL lock into the oscillator domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_async,
  output logic lock_s
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = lock_async;
    sync_d = meta_q;
  end

  // Synchronizer stages, cleared to "not locked".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign lock_s = sync_q;

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Drives PLL reset and loop-filter buses, qualifies lock, retries and re-locks.
// Optional lock-loss counter output enabled by defining PLL_DYN_LOSS_CNT_EN.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int               RST_CYCLES   = 16,
  parameter int               LOCK_STABLE  = 1024,
  parameter int               LOCK_TIMEOUT = 1048576,
  parameter int               MAX_RETRY    = 3,
  parameter logic [ICP_W-1:0] DEF_ICP      = DEF_ICP_C,
  parameter logic [RES_W-1:0] DEF_RES      = DEF_RES_C,
  parameter logic [CAP_W-1:0] DEF_CAP      = DEF_CAP_C
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ICP_W-1:0] req_icp,
  input  logic [RES_W-1:0] req_res,
  input  logic [CAP_W-1:0] req_cap,
  output logic             pll_reset,
  output logic [ICP_W-1:0] pll_icpsel,
  output logic [RES_W-1:0] pll_lpfres,
  output logic [CAP_W-1:0] pll_lpfcap,
  input  logic             pll_lock,
  output logic             locked,
  output logic             err,
`ifdef PLL_DYN_LOSS_CNT_EN
  output logic [1:0]       retry_cnt,
  output logic [7:0]       loss_cnt
`else
  output logic [1:0]       retry_cnt
`endif
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int ST_W = $clog2(LOCK_STABLE + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RC_W-1:0] RC_LOAD   = RC_W'(1);
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_MAX    = ST_W'(LOCK_STABLE);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(LOCK_TIMEOUT);
  localparam logic [1:0]      RETRY_MAX = 2'(MAX_RETRY);
  localparam filt_t           DEF_FILT  = '{icp: DEF_ICP, res: DEF_RES, cap: DEF_CAP};

  logic lock_s;

  pll_lock_sync u_lock_sync (
    .clk        (clk),
    .rst_n      (resetn),
    .lock_async (pll_lock),
    .lock_s     (lock_s)
  );

  state_e          state_q, state_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [ST_W-1:0] stab_q, stab_d, stab_nx_s;
  logic [TO_W-1:0] tmo_q, tmo_d, tmo_nx_s;
  logic [1:0]      retry_q, retry_d;
  filt_t           pend_q, pend_d;
  filt_t           filt_q, filt_d;
  logic            pll_reset_q, pll_reset_d;
  logic            locked_q, locked_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            accept_s;
  logic            loss_evt_s;

  assign accept_s = req_valid & ready_q;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = RC_W'(0);
    stab_d     = stab_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    pend_d     = pend_q;
    filt_d     = filt_q;
    loss_evt_s = 1'b0;
    tmo_nx_s   = tmo_q + TO_W'(1);
    if (lock_s) begin
      stab_nx_s = stab_q + ST_W'(1);
    end else begin
      stab_nx_s = ST_W'(0);
    end

    case (state_q)
      S_RST: begin
        // Filter buses move only once pll_reset has already been high a cycle.
        if (rst_cnt_q == RC_LOAD) begin
          filt_d = pend_q;
        end else begin
          filt_d = filt_q;
        end
        if (rst_cnt_q == RC_LAST) begin
          state_d = S_WAIT;
          stab_d  = ST_W'(0);
          tmo_d   = TO_W'(0);
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_WAIT: begin
        stab_d = stab_nx_s;
        tmo_d  = tmo_nx_s;
        if (stab_nx_s == ST_MAX) begin
          state_d = S_LOCKED;
        end else if (tmo_nx_s == TO_MAX) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = S_RST;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_LOCKED: begin
        if (accept_s) begin
          pend_d  = '{icp: req_icp, res: req_res, cap: req_cap};
          retry_d = 2'd0;
          state_d = S_RST;
        end else if (!lock_s) begin
          loss_evt_s = 1'b1;
          retry_d    = 2'd0;
          state_d    = S_RST;
        end else begin
          state_d = S_LOCKED;
        end
      end
      S_FAIL: begin
        if (accept_s) begin
          pend_d  = '{icp: req_icp, res: req_res, cap: req_cap};
          retry_d = 2'd0;
          state_d = S_RST;
        end else begin
          state_d = S_FAIL;
        end
      end
      default: begin
        state_d = S_RST;
      end
    endcase

    pll_reset_d = holds_pll_reset(state_d);
    locked_d    = (state_d == S_LOCKED);
    ready_d     = (state_d == S_LOCKED) || (state_d == S_FAIL);
    err_d       = (state_d == S_FAIL);
  end

  // Controller state and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_RST;
      rst_cnt_q   <= RC_W'(0);
      stab_q      <= ST_W'(0);
      tmo_q       <= TO_W'(0);
      retry_q     <= 2'd0;
      pend_q      <= DEF_FILT;
      filt_q      <= DEF_FILT;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stab_q      <= stab_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      pend_q      <= pend_d;
      filt_q      <= filt_d;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

`ifdef PLL_DYN_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  // Saturating count of genuine lock losses seen while locked.
  always_comb begin
    if (loss_evt_s && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      loss_q <= 8'd0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_cnt = loss_q;
`else
  logic unused_loss_s;
  assign unused_loss_s = loss_evt_s;
`endif

  assign req_ready  = ready_q;
  assign pll_reset  = pll_reset_q;
  assign pll_icpsel = filt_q.icp;
  assign pll_lpfres = filt_q.res;
  assign pll_lpfcap = filt_q.cap;
  assign locked     = locked_q;
  assign err        = err_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed + randomized bench for pll_dyn_ctrl with a timing-rule model of the PLL supervisor.
module tb_pll_dyn_ctrl;

  localparam int RC = 4;
  localparam int LS = 8;
  localparam int LT = 64;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [5:0] req_icp = 6'd0;
  logic [2:0] req_res = 3'd0;
  logic [1:0] req_cap = 2'd0;
  logic       pll_reset;
  logic [5:0] pll_icpsel;
  logic [2:0] pll_lpfres;
  logic [1:0] pll_lpfcap;
  logic       pll_lock = 1'b0;
  logic       locked;
  logic       err;
  logic [1:0] retry_cnt;
`ifdef PLL_DYN_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;
  int exp_icp = 20, exp_res = 2, exp_cap = 0, exp_retry = 0, exp_loss = 0;

  always #5 clk = ~clk;

  pll_dyn_ctrl #(.RST_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_icp    (req_icp),
    .req_res    (req_res),
    .req_cap    (req_cap),
    .pll_reset  (pll_reset),
    .pll_icpsel (pll_icpsel),
    .pll_lpfres (pll_lpfres),
    .pll_lpfcap (pll_lpfcap),
    .pll_lock   (pll_lock),
    .locked     (locked),
    .err        (err),
`ifdef PLL_DYN_LOSS_CNT_EN
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
`else
    .retry_cnt  (retry_cnt)
`endif
  );

  // Filter buses may only change when pll_reset was high on the previous and current sample.
  logic [10:0] prev_bus = 11'd0;
  logic        prev_rst_hi = 1'b1;
  logic        prev_rstn = 1'b0;
  always @(posedge clk) begin
    #2;
    if (resetn && prev_rstn && ({pll_icpsel, pll_lpfres, pll_lpfcap} !== prev_bus)
        && !(prev_rst_hi && pll_reset)) viol++;
    prev_bus    = {pll_icpsel, pll_lpfres, pll_lpfcap};
    prev_rst_hi = pll_reset;
    prev_rstn   = resetn;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic logic [31:0] exp_bus();
    return 32'(exp_icp * 32 + exp_res * 4 + exp_cap);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called where pll_reset has just risen; PLL model drops lock while in reset.
  task automatic reset_pulse(input string tag);
    int n = 0;
    pll_lock = 1'b0;
    while (pll_reset === 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    check({tag, " rst_len"}, n, RC);
    check({tag, " bus"}, {pll_icpsel, pll_lpfres, pll_lpfcap}, exp_bus());
    check({tag, " retry"}, retry_cnt, exp_retry);
    check({tag, " ready_low"}, req_ready, 0);
  endtask

  // Model PLL raises lock d cycles after reset fell; locked expected 2+LS edges later.
  task automatic wait_lock(input string tag, input int d);
    int n = 0;
    repeat (d) cyc();
    pll_lock = 1'b1;
    while (locked !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    check({tag, " lock_lat"}, n, 2 + LS);
    check({tag, " ready"}, req_ready, 1);
    check({tag, " err"}, err, 0);
    check({tag, " pll_rst"}, pll_reset, 0);
    check({tag, " retry"}, retry_cnt, exp_retry);
  endtask

  task automatic do_req(input string tag, input int icp, input int res, input int cap);
    check({tag, " ready_pre"}, req_ready, 1);
    req_valid = 1'b1;
    req_icp = 6'(icp);
    req_res = 3'(res);
    req_cap = 2'(cap);
    cyc();
    req_valid = 1'b0;
    exp_icp = icp;
    exp_res = res;
    exp_cap = cap;
    exp_retry = 0;
    check({tag, " ready_drop"}, req_ready, 0);
    check({tag, " pll_rst_hi"}, pll_reset, 1);
    check({tag, " locked_lo"}, locked, 0);
    check({tag, " err_lo"}, err, 0);
    check({tag, " retry_clr"}, retry_cnt, 0);
  endtask

  task automatic wait_timeout(input string tag);
    int n = 0;
    while (pll_reset === 1'b0 && n < 200) begin
      cyc();
      n++;
    end
    check({tag, " wait_len"}, n, LT);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " pll_rst"}, pll_reset, 1);
    check({tag, " bus"}, {pll_icpsel, pll_lpfres, pll_lpfcap}, exp_bus());
    check({tag, " locked"}, locked, 0);
    check({tag, " err"}, err, 0);
    check({tag, " ready"}, req_ready, 0);
    check({tag, " retry"}, retry_cnt, 0);
`ifdef PLL_DYN_LOSS_CNT_EN
    check({tag, " loss"}, loss_cnt, 0);
`endif
  endtask

  initial begin
    int n;
    // Power-up reset.
    #2 resetn = 1'b0;
    #1 check_reset_vals("por");
    repeat (3) cyc();
    resetn = 1'b1;
    reset_pulse("pwr");
    wait_lock("pwr", 20);

    // Request while locked.
    do_req("req1", 33, 5, 1);
    reset_pulse("req1");
    wait_lock("req1", $urandom_range(0, 30));

    // One-cycle lock glitch at stable count 5.
    do_req("gl", $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3));
    reset_pulse("gl");
    repeat ($urandom_range(0, 10)) cyc();
    pll_lock = 1'b1;
    repeat (2 + 5) cyc();
    pll_lock = 1'b0;
    cyc();
    wait_lock("gl", 0);

    // Lock and timeout in the same cycle: lock wins.
    do_req("tie", $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3));
    reset_pulse("tie");
    wait_lock("tie", LT - 2 - LS);

    // One cycle later the timeout wins and a retry follows.
    do_req("late", $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3));
    reset_pulse("late");
    repeat (LT - 1 - LS) cyc();
    pll_lock = 1'b1;
    n = LT - 1 - LS;
    while (pll_reset === 1'b0 && n < 200) begin
      cyc();
      n++;
    end
    check("late wait_len", n, LT);
    exp_retry = 1;
    reset_pulse("late_r");
    wait_lock("late_r", $urandom_range(0, 30));

    // Loss and request reach the FSM together.
    pll_lock = 1'b0;
    repeat (2) cyc();
    req_valid = 1'b1;
    req_icp = 6'(exp_icp ^ 7);
    req_res = 3'(exp_res ^ 1);
    req_cap = 2'(exp_cap ^ 2);
    exp_icp = exp_icp ^ 7;
    exp_res = exp_res ^ 1;
    exp_cap = exp_cap ^ 2;
    exp_retry = 0;
    cyc();
    req_valid = 1'b0;
    check("sim ready_drop", req_ready, 0);
    check("sim pll_rst_hi", pll_reset, 1);
    reset_pulse("sim");
    wait_lock("sim", $urandom_range(0, 30));
`ifdef PLL_DYN_LOSS_CNT_EN
    check("sim loss", loss_cnt, exp_loss);
`endif

    // Pure lock loss.
    pll_lock = 1'b0;
    n = 0;
    while (locked === 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("loss lat", n, 3);
    check("loss pll_rst", pll_reset, 1);
    exp_loss++;
    reset_pulse("loss");
    wait_lock("loss", $urandom_range(0, 30));
`ifdef PLL_DYN_LOSS_CNT_EN
    check("loss cnt", loss_cnt, exp_loss);
`endif

    // Randomized request/relock rounds.
    for (int i = 0; i < 5; i++) begin
      do_req("rnd", $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3));
      reset_pulse("rnd");
      wait_lock("rnd", $urandom_range(0, LT - 2 - LS));
    end

    // Lock never arrives: retries then FAIL.
    do_req("nl", $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3));
    reset_pulse("nl");
    for (int k = 0; k <= MR; k++) begin
      wait_timeout("nl");
      if (k < MR) begin
        exp_retry = k + 1;
        reset_pulse("nl_r");
      end
    end
    check("fail err", err, 1);
    check("fail ready", req_ready, 1);
    check("fail pll_rst", pll_reset, 1);
    check("fail retry", retry_cnt, MR);
    check("fail locked", locked, 0);
    repeat (20) cyc();
    check("fail hold err", err, 1);
    check("fail hold rst", pll_reset, 1);
    do_req("fx", $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3));
    reset_pulse("fx");

    // Asynchronous reset during WAIT after one retry.
    wait_timeout("ar");
    exp_retry = 1;
    reset_pulse("ar");
    repeat (5) cyc();
    resetn = 1'b0;
    #1;
    exp_icp = 20;
    exp_res = 2;
    exp_cap = 0;
    exp_retry = 0;
    exp_loss = 0;
    check_reset_vals("async");
    cyc();
    cyc();
    resetn = 1'b1;
    reset_pulse("rst2");
    wait_lock("rst2", $urandom_range(0, 30));

    check("bus_only_in_reset", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_dyn_ctrl.md
Name: pll_dyn_ctrl

Overview:
- Supervisor and driver for a PLL whose loop-filter settings (ICPSEL/LPFRES/LPFCAP) are dynamically selected. It is the controlling end of the `pll_hdmi_MOD` dynamic interface.
- It owns the PLL `reset` and the three filter buses. It applies new settings only while the PLL is held in reset, and qualifies `lock` with a stability window and a timeout.
- It retries on timeout and re-locks automatically after lock loss.
- It runs on the free-running board oscillator domain, never on the PLL's own output.

Parameters:
- RST_CYCLES, 16: cycles `pll_reset` is held high per attempt.
- LOCK_STABLE, 1024: consecutive synchronized lock-high cycles required to declare lock.
- LOCK_TIMEOUT, 1048576: cycles in WAIT before an attempt is declared failed. Counter width is `$clog2(LOCK_TIMEOUT+1)`.
- MAX_RETRY, 3: retries of the same settings after the first attempt before FAIL.
- DEF_ICP, 6'd20: ICPSEL applied after `resetn` release.
- DEF_RES, 3'd2: LPFRES applied after `resetn` release.
- DEF_CAP, 2'd0: LPFCAP applied after `resetn` release.

Ports:
- `clk`, in, 1: oscillator clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: new filter-setting request.
- `req_ready`, out, 1: request accepted when `req_valid & req_ready`.
- `req_icp`, in, 6: requested ICPSEL.
- `req_res`, in, 3: requested LPFRES.
- `req_cap`, in, 2: requested LPFCAP.
- `pll_reset`, out, 1: to PLL `reset`.
- `pll_icpsel`, out, 6: to PLL `icpsel`.
- `pll_lpfres`, out, 3: to PLL `lpfres`.
- `pll_lpfcap`, out, 2: to PLL `lpfcap`.
- `pll_lock`, in, 1: raw PLL lock, asynchronous to `clk`.
- `locked`, out, 1: qualified lock status.
- `err`, out, 1: lock failed after all retries.
- `retry_cnt`, out, 2: retries used in the current attempt sequence.

Behaviour:

Reset state (`resetn` low):
- `pll_reset`=1, `pll_icpsel/lpfres/lpfcap` = DEF_*, `locked`=0, `err`=0, `req_ready`=0, `retry_cnt`=0.
- Pending settings = DEF_*.
- State = S_RST with counter 0.
- `resetn` asserted mid-operation aborts everything immediately, asynchronously.

Lock synchronization:
- `pll_lock` passes through a 2-flop synchronizer (`lock_s`). Lock latency as seen by the FSM is 2 cycles.

Output timing:
- All outputs are registered; there are no combinational paths from inputs to outputs.

FSM:
- S_RST:
  - `pll_reset`=1, `locked`=0, `req_ready`=0.
  - Counter cycle 1: filter outputs load from the pending registers. Filter buses therefore change only while `pll_reset` has been high for at least 1 cycle.
  - After RST_CYCLES cycles: go to S_WAIT, clearing the timeout and stable counters.
- S_WAIT:
  - `pll_reset`=0.
  - Stable counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - Stable counter reaches LOCK_STABLE: go to S_LOCKED.
  - Timeout counter reaches LOCK_TIMEOUT first:
    - if `retry_cnt` < MAX_RETRY: `retry_cnt`++ and go to S_RST;
    - otherwise go to S_FAIL.
  - If both counters reach their limit in the same cycle, lock wins.
- S_LOCKED:
  - `locked`=1, `req_ready`=1.
  - `req_valid` accepted: latch the request into pending, clear `retry_cnt`, go to S_RST.
  - `lock_s`=0 (lock loss): clear `retry_cnt`, go to S_RST with the current settings unchanged.
  - Request and loss in the same cycle: the request is taken and a single reset sequence runs.
- S_FAIL:
  - `err`=1, `pll_reset`=1 held, `req_ready`=1.
  - Accepted request: `err`=0, `retry_cnt`=0, go to S_RST.
  - No automatic exit.

Handshake:
- `req_ready` is low in S_RST and S_WAIT. Requesters hold `req_valid` and the request data stable until accepted.
- `req_ready` deasserts in the cycle after acceptance, so back-to-back acceptance is impossible.

Optional Feature:

Macro `PLL_DYN_LOSS_CNT_EN`.
- Defined:
  - Adds output `loss_cnt` [7:0]: a saturating count of lock-loss events detected in S_LOCKED.
  - Requests do not count as losses.
  - Resets to 0; saturates at 255; cleared only by `resetn`.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Package `pll_dyn_pkg`:
  - state enum {S_RST, S_WAIT, S_LOCKED, S_FAIL};
  - widths ICP_W=6, RES_W=3, CAP_W=2;
  - default-setting constants.
- One sub-module, `pll_lock_sync`: the 2-flop synchronizer for `pll_lock`, with async active-low reset to 0.
- Counters and FSM stay in `pll_dyn_ctrl`.

Test Plan:
Benches override RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64.
1. Power-up: release `resetn`, model PLL raises lock 20 cycles after `pll_reset` falls -> filter buses = 20/2/0 throughout, `pll_reset` high 4 cycles, `locked`=1 exactly 2+8 cycles after lock rises, `err`=0.
2. Request in LOCKED: `req_icp`=33, `req_res`=5, `req_cap`=1 -> accepted in 1 cycle, `pll_reset` rises before buses change to 33/5/1, `locked` drops then re-asserts after model relocks.
3. Lock never rises -> 3 retries (`retry_cnt` 1, 2, 3), then S_FAIL: `err`=1, `pll_reset`=1, `req_ready`=1. A new request clears `err` and restarts.
4. Lock glitches low 1 cycle at stable count 5 in S_WAIT -> stable counter restarts, `locked` asserts 8 cycles after the glitch ends.
5. Lock loss in LOCKED simultaneous with `req_valid` -> a single 4-cycle reset, new settings applied. With `PLL_DYN_LOSS_CNT_EN`, `loss_cnt` stays 0; a later pure loss gives `loss_cnt`=1.
6. `resetn` asserted during S_WAIT -> all outputs return to reset values in the same cycle, asynchronously.
